// File: rtl/freq_gate_controller.sv
// Gate-timing controller: snapshots a synchronised gray count at both edges of a
// programmable window and reports the binary difference as the event count.
module freq_gate_controller #(
   parameter int unsigned CNT_WIDTH  = 32,
   parameter int unsigned GATE_WIDTH = 27
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CNT_WIDTH-1:0]  gray_in,
   input  logic [GATE_WIDTH-1:0] gate_len,
   input  logic                  start,
   input  logic                  continuous,
   input  logic                  stop,
   output logic                  busy,
   output logic                  gate_open,
   output logic [CNT_WIDTH-1:0]  result,
   output logic                  result_valid,
   output logic                  gray_err
);

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_t;

   state_t                state, state_d;
   logic [CNT_WIDTH-1:0]  g_q, bin_q, bin_d;
   logic [CNT_WIDTH-1:0]  start_snap, snap_d, result_d;
   logic [CNT_WIDTH-1:0]  diff;
   logic [GATE_WIDTH-1:0] timer, timer_d;
   logic                  rv_d, err_d, multi_bit, accept;

   always_comb begin
      bin_d = '0;
      for (int unsigned i = 0; i < CNT_WIDTH; i++) begin
         bin_d[i] = ^(g_q >> i);
      end
   end

   // More than one bit set in the change mask <=> clearing the lowest set bit leaves something.
   always_comb begin
      diff      = gray_in ^ g_q;
      multi_bit = |(diff & (diff - CNT_WIDTH'(1)));
   end

   assign accept    = (state == IDLE) && start && (gate_len != '0);
   assign busy      = (state != IDLE);
   assign gate_open = (state == GATE);

   always_comb begin
      state_d  = state;
      timer_d  = timer;
      snap_d   = start_snap;
      result_d = result;
      rv_d     = 1'b0;
      err_d    = multi_bit ? 1'b1 : (accept ? 1'b0 : gray_err);
      case (state)
         IDLE: begin
            if (accept) begin
               snap_d  = bin_q;
               timer_d = gate_len - GATE_WIDTH'(1);
               state_d = GATE;
            end
         end
         GATE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (timer != '0) begin
               timer_d = timer - GATE_WIDTH'(1);
            end else begin
               result_d = bin_q - start_snap;
               rv_d     = 1'b1;
               // End snapshot doubles as the next start snapshot: no dead time between windows.
               if (continuous && (gate_len != '0)) begin
                  snap_d  = bin_q;
                  timer_d = gate_len - GATE_WIDTH'(1);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         g_q          <= '0;
         bin_q        <= '0;
         start_snap   <= '0;
         timer        <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         gray_err     <= 1'b0;
      end else begin
         state        <= state_d;
         g_q          <= gray_in;
         bin_q        <= bin_d;
         start_snap   <= snap_d;
         timer        <= timer_d;
         result       <= result_d;
         result_valid <= rv_d;
         gray_err     <= err_d;
      end
   end

endmodule
